if_stage_pipe: RTL and testbench
================================

Name: if_stage_pipe

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS datapath.
- Owns the program counter and drives the address of the combinational instruction memory.
- Registers the fetched instruction and PC+4 into IF/ID for the decode stage.
- Handles hazard stalls, branch/jump redirects with wrong-path squash, a misaligned-target fault state, and fetch/bubble performance counters.

Parameters:
WIDTH, 32, PC/instruction/data width in bits
RESET_PC, 32'h00000000, PC value loaded on reset
BUB_W, 16, width of saturating bubble counter

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
imem_addr  output  WIDTH  instruction memory address; combinational copy of the PC register
imem_data  input  WIDTH  instruction word returned combinationally for imem_addr
stall  input  1  hazard unit hold request: freeze PC and IF/ID
redirect  input  1  taken branch or jump: load redirect_pc and squash IF/ID
redirect_pc  input  WIDTH  redirect target; must be word aligned
if_id_instr  output  WIDTH  IF/ID registered instruction (0 = nop when invalid)
if_id_pc4  output  WIDTH  IF/ID registered PC+4 of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
fetch_err  output  1  sticky: misaligned redirect seen; stage halted
fetch_count  output  32  instructions delivered into IF/ID, wraps mod 2^32
bubble_count  output  BUB_W  stall/redirect cycles in RUN, saturating

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; reset is only sampled at the posedge.
- Reset values: PC = RESET_PC, so imem_addr = RESET_PC in the next cycle. All other outputs reset to 0: if_id_instr, if_id_pc4, if_id_valid, fetch_err, fetch_count, bubble_count. State = RUN.
- imem_addr = PC register; no combinational path from stall or redirect.
- States: RUN and HALT. fetch_err = (state == HALT).
- RUN, per-posedge priority: reset > redirect > stall > advance.
  - redirect with redirect_pc[1:0] == 00:
    - PC <= redirect_pc; if_id_valid <= 0; if_id_instr <= 0; if_id_pc4 <= 0.
    - bubble_count += 1 (saturating). Overrides a simultaneous stall.
  - redirect with redirect_pc[1:0] != 00:
    - state <= HALT; PC holds; IF/ID squashed as above.
    - bubble_count += 1 (saturating).
  - stall (no redirect): PC, if_id_* and fetch_count hold; bubble_count += 1 (saturating).
  - advance:
    - PC <= PC + 4, wrapping modulo 2^WIDTH, so 32'hFFFFFFFC -> 0.
    - if_id_instr <= imem_data; if_id_pc4 <= PC + 4 (same wrap); if_id_valid <= 1.
    - fetch_count += 1.
- HALT:
  - PC frozen; if_id_valid = 0; if_id_instr = 0.
  - stall and redirect are ignored; counters frozen.
  - Only reset exits, to RUN.
- Latency:
  - Instruction at address A appears on if_id_instr one posedge after imem_addr == A with no stall/redirect.
  - First valid IF/ID is in the second cycle after reset deasserts.
- bubble_count saturates at 2^BUB_W-1 and never wraps. fetch_count wraps to 0.
- Reset asserted mid-stall or mid-redirect: reset wins, all state returns to reset values.
- Redirect while IF/ID holds a stalled valid instruction: that instruction is discarded (valid 0). The decode stage is responsible for not stalling on a branch it has already resolved.

Test Plan:
- Reset/linear fetch:
  - Stimulus: reset for 2 cycles, imem returns 32'h20080005 at addr 0 and 32'h20090003 at addr 4.
  - Response: cycle 1 after reset shows imem_addr=0, valid=0. Next shows if_id_instr=32'h20080005, if_id_pc4=4, valid=1, imem_addr=8, then if_id_instr=32'h20090003, fetch_count=2.
- Stall hold:
  - Stimulus: at PC=8, assert stall for 3 cycles.
  - Response: imem_addr stays 8 and IF/ID is unchanged for 3 cycles; bubble_count=3; fetch_count unchanged. The cycle after release loads addr 8's word with pc4=12.
- Redirect with squash:
  - Stimulus: at PC=12, assert redirect with redirect_pc=32'h40 together with stall.
  - Response: next cycle imem_addr=32'h40, valid=0, if_id_instr=0. The following cycle shows if_id_pc4=32'h44, valid=1.
- Misaligned redirect:
  - Stimulus: redirect_pc=32'h42.
  - Response: fetch_err=1, imem_addr frozen, valid=0, and the stage ignores further redirect to 32'h80. Reset then clears fetch_err and gives imem_addr=0.
- Wrap:
  - Stimulus: redirect to 32'hFFFFFFFC, then advance.
  - Response: if_id_pc4=0 and imem_addr=0.
- Saturation:
  - Stimulus: BUB_W=4, hold stall for 20 cycles.
  - Response: bubble_count stops at 15.

Source files
------------

// File: rtl/if_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_pipe
// Purpose  : Instruction-fetch stage and IF/ID pipeline register. Owns the
//            PC, drives the combinational instruction memory address, and
//            handles stalls, redirects with squash, a misaligned-target
//            halt, and fetch/bubble performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage_pipe #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h00000000,
    parameter int               BUB_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc4,
    output logic             if_id_valid,
    output logic             fetch_err,
    output logic [31:0]      fetch_count,
    output logic [BUB_W-1:0] bubble_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_PC_STEP = WIDTH'(4);
    localparam logic [BUB_W-1:0] c_BUB_MAX = {BUB_W{1'b1}};

    state_t           r_state_q,  w_state_d;
    logic [WIDTH-1:0] r_pc_q,     w_pc_d;
    logic [WIDTH-1:0] r_instr_q,  w_instr_d;
    logic [WIDTH-1:0] r_pc4_q,    w_pc4_d;
    logic             r_valid_q,  w_valid_d;
    logic [31:0]      r_fetch_q,  w_fetch_d;
    logic [BUB_W-1:0] r_bub_q,    w_bub_d;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [BUB_W-1:0] w_bub_inc;

    // Sequential PC increment wraps naturally modulo 2^WIDTH.
    assign w_pc_plus4 = r_pc_q + c_PC_STEP;
    // Bubble counter sticks at all-ones instead of wrapping.
    assign w_bub_inc  = (r_bub_q == c_BUB_MAX) ? r_bub_q : r_bub_q + 1'b1;

    // Next-state logic: redirect beats stall beats advance; HALT freezes all.
    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_pc4_d   = r_pc4_q;
        w_valid_d = r_valid_q;
        w_fetch_d = r_fetch_q;
        w_bub_d   = r_bub_q;
        if (r_state_q == RUN) begin
            if (redirect) begin
                // Wrong-path instruction in IF/ID is squashed either way.
                w_instr_d = '0;
                w_pc4_d   = '0;
                w_valid_d = 1'b0;
                w_bub_d   = w_bub_inc;
                if (redirect_pc[1:0] == 2'b00) begin
                    w_pc_d = redirect_pc;
                end else begin
                    w_state_d = HALT;
                end
            end else if (stall) begin
                w_bub_d = w_bub_inc;
            end else begin
                w_pc_d    = w_pc_plus4;
                w_instr_d = imem_data;
                w_pc4_d   = w_pc_plus4;
                w_valid_d = 1'b1;
                w_fetch_d = r_fetch_q + 32'd1;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= RUN;
            r_pc_q    <= RESET_PC;
            r_instr_q <= '0;
            r_pc4_q   <= '0;
            r_valid_q <= 1'b0;
            r_fetch_q <= '0;
            r_bub_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_pc4_q   <= w_pc4_d;
            r_valid_q <= w_valid_d;
            r_fetch_q <= w_fetch_d;
            r_bub_q   <= w_bub_d;
        end
    end

    assign imem_addr    = r_pc_q;
    assign if_id_instr  = r_instr_q;
    assign if_id_pc4    = r_pc4_q;
    assign if_id_valid  = r_valid_q;
    assign fetch_err    = (r_state_q == HALT);
    assign fetch_count  = r_fetch_q;
    assign bubble_count = r_bub_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage_pipe
// Purpose  : Self-checking bench for if_stage_pipe (BUB_W = 4). Vectors hold
//            per-cycle inputs and the outputs expected after the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage_pipe;

    localparam int WIDTH = 32;
    localparam int BUB_W = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_data;
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] if_id_instr;
    logic [WIDTH-1:0] if_id_pc4;
    logic             if_id_valid;
    logic             fetch_err;
    logic [31:0]      fetch_count;
    logic [BUB_W-1:0] bubble_count;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
        logic [31:0] fcnt;
        logic [31:0] bcnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    if_stage_pipe #(
        .WIDTH    (WIDTH),
        .RESET_PC (32'h00000000),
        .BUB_W    (BUB_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fetch_err    (fetch_err),
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h20080005;
        else if (a == 32'h4) return 32'h20090003;
        else                 return a ^ 32'hDEAD0000;
    endfunction

    assign imem_data = mem_word(imem_addr);

    function automatic vec_t mk(input logic r, input logic s, input logic d,
                                input logic [31:0] rp, input logic [31:0] ad,
                                input logic [31:0] ins, input logic [31:0] p4,
                                input logic v, input logic e,
                                input logic [31:0] fc, input logic [31:0] bc);
        vec_t t;
        t.rst = r;  t.stl = s;  t.rdr = d;  t.rpc = rp;
        t.addr = ad; t.instr = ins; t.pc4 = p4; t.valid = v; t.err = e;
        t.fcnt = fc; t.bcnt = bc;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, check after the next rising edge
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        reset       = v.rst;
        stall       = v.stl;
        redirect    = v.rdr;
        redirect_pc = v.rpc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("imem_addr",    idx, imem_addr,           e.addr);
        chk("if_id_instr",  idx, if_id_instr,         e.instr);
        chk("if_id_pc4",    idx, if_id_pc4,           e.pc4);
        chk("if_id_valid",  idx, {31'b0, if_id_valid}, {31'b0, e.valid});
        chk("fetch_err",    idx, {31'b0, fetch_err},   {31'b0, e.err});
        chk("fetch_count",  idx, fetch_count,         e.fcnt);
        chk("bubble_count", idx, {28'b0, bubble_count}, e.bcnt);
    endtask

    initial begin
        logic [31:0] w40;
        logic [31:0] wfc;
        logic [31:0] w8;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        w8  = mem_word(32'h8);
        w40 = mem_word(32'h40);
        wfc = mem_word(32'hFFFFFFFC);

        //            rst stl rdr rpc           addr          instr         pc4           v  e  fc bc
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4,        32'h20080005, 32'h4,        1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h8,        32'h20090003, 32'h8,        1, 0, 2, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h8,        32'h20090003, 32'h8,        1, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h8,        32'h20090003, 32'h8,        1, 0, 2, 2));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h8,        32'h20090003, 32'h8,        1, 0, 2, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'hC,        w8,           32'hC,        1, 0, 3, 3));
        vecs.push_back(mk(0, 1, 1, 32'h40,       32'h40,       32'h0,        32'h0,        0, 0, 3, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h44,       w40,          32'h44,       1, 0, 4, 4));
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 0, 4, 5));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        wfc,          32'h0,        1, 0, 5, 5));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4,        32'h20080005, 32'h4,        1, 0, 6, 5));
        vecs.push_back(mk(0, 0, 1, 32'h42,       32'h4,        32'h0,        32'h0,        0, 1, 6, 6));
        vecs.push_back(mk(0, 1, 1, 32'h80,       32'h4,        32'h0,        32'h0,        0, 1, 6, 6));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h0,        0, 1, 6, 6));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4,        32'h20080005, 32'h4,        1, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Saturation: 20 stall cycles, counter must stop at 15
        for (int i = 0; i < 20; i++) begin
            apply(mk(0, 1, 0, 32'h0, 32'h4, 32'h20080005, 32'h4, 1, 0, 1,
                     (i + 1 > 15) ? 32'd15 : 32'(i + 1)), 100 + i);
        end
        // Stalled valid instruction discarded by a redirect; counter stays saturated
        apply(mk(0, 1, 1, 32'h100, 32'h100, 32'h0, 32'h0, 0, 0, 1, 15), 200);
        // Reset asserted during stall and redirect wins
        apply(mk(1, 1, 1, 32'h200, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0), 201);
        // Reset while halted returns to RUN
        apply(mk(0, 0, 1, 32'h3, 32'h0, 32'h0, 32'h0, 0, 1, 0, 1), 202);
        apply(mk(1, 1, 1, 32'h3, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0), 203);
        apply(mk(0, 0, 0, 32'h0, 32'h4, 32'h20080005, 32'h4, 1, 0, 1, 0), 204);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
